// File: rtl/i2s_pkg.sv
// i2s_pkg: shared encodings for the I2S / left-justified / DSP-TDM
// frame controller.
package i2s_pkg;

   typedef enum logic [1:0] {
      MODE_I2S  = 2'd0,
      MODE_LJ   = 2'd1,
      MODE_DSP  = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // ws level held on the line while no frame is being generated
   function automatic logic idle_ws(mode_e m);
      return (m == MODE_LJ);
   endfunction

endpackage

// File: rtl/i2s_tdm_if.sv
// i2s_tdm_if: configuration inputs and serial framing outputs of the
// I2S/TDM controller; master is the controller side.
interface i2s_tdm_if #(
   parameter int SLOT_WIDTH     = 32,
   parameter int CHANNELS       = 8,
   parameter int PRESCALE_WIDTH = 16
);
   localparam int SW = $clog2(SLOT_WIDTH);
   localparam int CW = $clog2(CHANNELS);

   logic                      enable;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [SW-1:0]             cfg_slot_bits;
   logic [CW-1:0]             cfg_slots;
   logic [1:0]                cfg_mode;
   logic                      sck;
   logic                      ws;
   logic                      bit_strobe;
   logic                      frame_start;
   logic [CW-1:0]             slot;
   logic [SW-1:0]             bit_idx;
   logic                      busy;

   modport master (
      input  enable, prescale, cfg_slot_bits, cfg_slots, cfg_mode,
      output sck, ws, bit_strobe, frame_start, slot, bit_idx, busy
   );

   modport slave (
      output enable, prescale, cfg_slot_bits, cfg_slots, cfg_mode,
      input  sck, ws, bit_strobe, frame_start, slot, bit_idx, busy
   );

endinterface

// File: rtl/i2s_clk_div.sv
// i2s_clk_div: prescale counter producing sck rise/fall enables; the
// reload value is re-read at every expiry.
module i2s_clk_div #(
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_load,
   input  logic                      i_run,
   input  logic                      i_sck,
   input  logic [PRESCALE_WIDTH-1:0] i_prescale,
   output logic                      o_rise,
   output logic                      o_fall
);

   logic [PRESCALE_WIDTH-1:0] r_cnt;
   logic                      w_tick;

   assign w_tick = i_run && (r_cnt == '0);
   assign o_rise = w_tick && !i_sck;
   assign o_fall = w_tick && i_sck;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load || w_tick) begin
         r_cnt <= i_prescale;
      end else if (i_run) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/i2s_tdm_ctrl.sv
// i2s_tdm_ctrl: I2S / left-justified / DSP-TDM frame generator with
// shadowed per-frame configuration and drain-to-frame-end stop.
module i2s_tdm_ctrl
   import i2s_pkg::*;
#(
   parameter int SLOT_WIDTH     = 32,
   parameter int CHANNELS       = 8,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   i2s_tdm_if.master bus
);

   localparam int SW = $clog2(SLOT_WIDTH);
   localparam int CW = $clog2(CHANNELS);

   state_e        r_state, w_state;
   mode_e         r_sh_mode, w_sh_mode, w_cfg_mode;
   logic [SW-1:0] r_sh_bits, w_sh_bits, w_cfg_bits;
   logic [CW-1:0] r_sh_slots, w_sh_slots, w_cfg_slots;
   logic [SW-1:0] r_bit_idx, w_bit_idx;
   logic [CW-1:0] r_slot, w_slot;
   logic          r_sck, w_sck;
   logic          r_ws, w_ws;
   logic          r_bs, w_bs;
   logic          r_fs, w_fs;
   logic          r_first, w_first;
   logic          w_start, w_run, w_rise, w_fall;

   // ws for bit b of slot s; I2S looks one bit ahead into the next slot
   function automatic logic f_ws(mode_e m, logic [CW-1:0] s,
                                 logic [SW-1:0] b, logic [CW-1:0] n);
      logic [CW-1:0] nxt;
      nxt = (s == n) ? '0 : s + 1'b1;
      case (m)
         MODE_LJ:  f_ws = (s <= (n >> 1));
         MODE_DSP: f_ws = (s == n) && (b == '0);
         default:  f_ws = (b == '0) ? (nxt > (n >> 1)) : (s > (n >> 1));
      endcase
   endfunction

   assign w_cfg_bits  = (bus.cfg_slot_bits == '0) ? SW'(1) : bus.cfg_slot_bits;
   assign w_cfg_slots = (bus.cfg_slots == '0) ? CW'(1) : bus.cfg_slots;
   assign w_cfg_mode  = mode_e'(bus.cfg_mode);
   assign w_start     = (r_state == ST_IDLE) && bus.enable;
   assign w_run       = (r_state != ST_IDLE);

   i2s_clk_div #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_start),
      .i_run      (w_run),
      .i_sck      (r_sck),
      .i_prescale (bus.prescale),
      .o_rise     (w_rise),
      .o_fall     (w_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_sh_mode  <= MODE_I2S;
         r_sh_bits  <= '0;
         r_sh_slots <= '0;
         r_bit_idx  <= '0;
         r_slot     <= '0;
         r_sck      <= 1'b0;
         r_ws       <= 1'b0;
         r_bs       <= 1'b0;
         r_fs       <= 1'b0;
         r_first    <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_sh_mode  <= w_sh_mode;
         r_sh_bits  <= w_sh_bits;
         r_sh_slots <= w_sh_slots;
         r_bit_idx  <= w_bit_idx;
         r_slot     <= w_slot;
         r_sck      <= w_sck;
         r_ws       <= w_ws;
         r_bs       <= w_bs;
         r_fs       <= w_fs;
         r_first    <= w_first;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_sh_mode  = r_sh_mode;
      w_sh_bits  = r_sh_bits;
      w_sh_slots = r_sh_slots;
      w_bit_idx  = r_bit_idx;
      w_slot     = r_slot;
      w_sck      = r_sck;
      w_ws       = r_ws;
      w_first    = r_first;
      w_bs       = 1'b0;
      w_fs       = 1'b0;

      unique case (r_state)
         ST_IDLE:  if (bus.enable)  w_state = ST_RUN;
         ST_RUN:   if (!bus.enable) w_state = ST_DRAIN;
         ST_DRAIN: if (bus.enable)  w_state = ST_RUN;
         default:  w_state = ST_IDLE;
      endcase

      if (w_start) begin
         w_sh_bits  = w_cfg_bits;
         w_sh_slots = w_cfg_slots;
         w_sh_mode  = w_cfg_mode;
         w_slot     = '0;
         w_bit_idx  = w_cfg_bits;
         w_first    = 1'b1;
         w_ws       = f_ws(w_cfg_mode, '0, w_cfg_bits, w_cfg_slots);
      end

      // the very first frame has no preceding fall, so it is marked on the rise
      if (w_rise) begin
         w_sck   = 1'b1;
         w_fs    = r_first;
         w_first = 1'b0;
      end

      if (w_fall) begin
         w_sck = 1'b0;
         w_bs  = 1'b1;
         if (r_bit_idx != '0) begin
            w_bit_idx = r_bit_idx - 1'b1;
            w_ws      = f_ws(r_sh_mode, r_slot, w_bit_idx, r_sh_slots);
         end else if (r_slot != r_sh_slots) begin
            w_slot    = r_slot + 1'b1;
            w_bit_idx = r_sh_bits;
            w_ws      = f_ws(r_sh_mode, w_slot, r_sh_bits, r_sh_slots);
         end else if (!bus.enable) begin
            w_state   = ST_IDLE;
            w_slot    = '0;
            w_bit_idx = '0;
            w_ws      = idle_ws(r_sh_mode);
         end else begin
            w_sh_bits  = w_cfg_bits;
            w_sh_slots = w_cfg_slots;
            w_sh_mode  = w_cfg_mode;
            w_slot     = '0;
            w_bit_idx  = w_cfg_bits;
            w_fs       = 1'b1;
            w_ws       = f_ws(w_cfg_mode, '0, w_cfg_bits, w_cfg_slots);
         end
      end
   end

   assign bus.sck         = r_sck;
   assign bus.ws          = r_ws;
   assign bus.bit_strobe  = r_bs;
   assign bus.frame_start = r_fs;
   assign bus.slot        = r_slot;
   assign bus.bit_idx     = r_bit_idx;
   assign bus.busy        = w_run;

endmodule

// File: tb/tb_i2s_tdm_ctrl.sv
// tb_i2s_tdm_ctrl: directed checks of framing, modes, shadowing,
// drain, reset and prescale changes.
module tb_i2s_tdm_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   i2s_tdm_if #(
      .SLOT_WIDTH(32), .CHANNELS(8), .PRESCALE_WIDTH(16)
   ) bus_if ();

   i2s_tdm_ctrl #(
      .SLOT_WIDTH(32), .CHANNELS(8), .PRESCALE_WIDTH(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // latency counted in posedges including the one that samples enable
   task automatic start_rise(input string tag, input int exp_lat);
      int n;
      n = 0;
      @(negedge clk);
      bus_if.enable = 1'b1;
      do begin
         tick();
         n++;
      end while (!bus_if.sck && n < 100);
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_fs"}, int'(bus_if.frame_start), 1);
   endtask

   task automatic stop_idle(input string tag);
      int n;
      n = 0;
      bus_if.enable = 1'b0;
      while (bus_if.busy && n < 3000) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, int'(bus_if.busy), 0);
   endtask

   // call right after a frame_start sample; runs to the next frame_start
   task automatic run_frame(input int chg_at, input logic [4:0] chg_bits,
                            output int n_bs, output int ws_up,
                            output int ws_dn, output int n_clk);
      logic pw;
      n_bs  = 0;
      ws_up = -1;
      ws_dn = -1;
      n_clk = 0;
      pw    = bus_if.ws;
      while (n_clk < 4000) begin
         tick();
         n_clk++;
         if (bus_if.bit_strobe) n_bs++;
         if (bus_if.ws && !pw && ws_up < 0) ws_up = n_bs;
         if (!bus_if.ws && pw && ws_dn < 0) ws_dn = n_bs;
         pw = bus_if.ws;
         if (n_bs == chg_at) bus_if.cfg_slot_bits = chg_bits;
         if (bus_if.frame_start) break;
      end
      chk("frame_end_seen", int'(bus_if.frame_start), 1);
   endtask

   initial begin
      int   nb, wu, wd, nc, n, k, mx, gap, nf, fsn;
      int   iv [5];
      logic pw;

      rst_n                = 1'b0;
      bus_if.enable        = 1'b0;
      bus_if.prescale      = 16'd1;
      bus_if.cfg_slot_bits = 5'd15;
      bus_if.cfg_slots     = 3'd1;
      bus_if.cfg_mode      = 2'd0;
      for (int i = 0; i < 5; i++) iv[i] = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_sck",  int'(bus_if.sck), 0);
      chk("rst_ws",   int'(bus_if.ws), 0);
      chk("rst_bs",   int'(bus_if.bit_strobe), 0);
      chk("rst_fs",   int'(bus_if.frame_start), 0);
      chk("rst_slot", int'(bus_if.slot), 0);
      chk("rst_bit",  int'(bus_if.bit_idx), 0);
      chk("rst_busy", int'(bus_if.busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", int'(bus_if.busy), 0);

      // I2S, 2 x 16 bit, prescale 1
      start_rise("i2s", 3);
      chk("i2s_msb", int'(bus_if.bit_idx), 15);
      run_frame(-1, 5'd0, nb, wu, wd, nc);
      chk("i2s_nbs", nb, 32);
      chk("i2s_ws_up", wu, 15);
      chk("i2s_ws_dn", wd, 31);
      run_frame(-1, 5'd0, nb, wu, wd, nc);
      chk("i2s_clk", nc, 128);
      stop_idle("i2s");

      // DSP/TDM, 8 x 32 bit
      bus_if.cfg_slots     = 3'd7;
      bus_if.cfg_slot_bits = 5'd31;
      bus_if.cfg_mode      = 2'd2;
      start_rise("dsp", 3);
      run_frame(-1, 5'd0, nb, wu, wd, nc);
      chk("dsp_nbs", nb, 256);
      chk("dsp_ws_up", wu, 255);
      chk("dsp_ws_dn", wd, 256);
      run_frame(-1, 5'd0, nb, wu, wd, nc);
      chk("dsp_clk", nc, 1024);
      stop_idle("dsp");

      // mid-frame slot width change
      bus_if.cfg_slots     = 3'd1;
      bus_if.cfg_slot_bits = 5'd15;
      bus_if.cfg_mode      = 2'd0;
      start_rise("chg", 3);
      run_frame(5, 5'd23, nb, wu, wd, nc);
      chk("chg_cur_nbs", nb, 32);
      chk("chg_latch", int'(bus_if.bit_idx), 23);
      run_frame(-1, 5'd0, nb, wu, wd, nc);
      chk("chg_nxt_nbs", nb, 48);
      chk("chg_ws_up", wu, 23);
      chk("chg_ws_dn", wd, 47);
      bus_if.cfg_slot_bits = 5'd15;
      run_frame(-1, 5'd0, nb, wu, wd, nc);
      chk("chg_back", int'(bus_if.bit_idx), 15);

      // drop enable at slot 0 bit 10
      n = 0;
      while (!(bus_if.slot == 3'd0 && bus_if.bit_idx == 5'd10) && n < 200) begin
         tick();
         n++;
      end
      chk("drop_pos", int'(bus_if.bit_idx), 10);
      bus_if.enable = 1'b0;
      nb  = 0;
      fsn = 0;
      n   = 0;
      do begin
         tick();
         n++;
         if (bus_if.bit_strobe) nb++;
         if (bus_if.frame_start) fsn++;
      end while (bus_if.busy && n < 500);
      chk("drain_nbs",  nb, 27);
      chk("drain_fs",   fsn, 0);
      chk("drain_busy", int'(bus_if.busy), 0);
      chk("drain_sck",  int'(bus_if.sck), 0);
      chk("drain_ws",   int'(bus_if.ws), 0);
      chk("drain_slot", int'(bus_if.slot), 0);
      chk("drain_bit",  int'(bus_if.bit_idx), 0);
      repeat (5) tick();
      chk("idle_sck_hold", int'(bus_if.sck), 0);

      // re-enable while draining
      start_rise("re", 3);
      repeat (10) tick();
      bus_if.enable = 1'b0;
      repeat (3) tick();
      chk("re_drain_busy", int'(bus_if.busy), 1);
      bus_if.enable = 1'b1;
      pw  = bus_if.sck;
      gap = 0;
      mx  = 0;
      n   = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         gap++;
         if (bus_if.sck != pw) begin
            if (gap > mx) mx = gap;
            gap = 0;
         end
         pw = bus_if.sck;
         if (!bus_if.busy) n++;
      end
      if (gap > mx) mx = gap;
      chk("re_gap", mx, 2);
      chk("re_idle_cyc", n, 0);

      // asynchronous reset mid-frame
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_sck",  int'(bus_if.sck), 0);
      chk("arst_ws",   int'(bus_if.ws), 0);
      chk("arst_bs",   int'(bus_if.bit_strobe), 0);
      chk("arst_fs",   int'(bus_if.frame_start), 0);
      chk("arst_slot", int'(bus_if.slot), 0);
      chk("arst_bit",  int'(bus_if.bit_idx), 0);
      chk("arst_busy", int'(bus_if.busy), 0);
      repeat (3) @(posedge clk);
      bus_if.enable   = 1'b0;
      bus_if.prescale = 16'd2;
      #2;
      rst_n = 1'b1;
      tick();
      tick();
      chk("arst_idle", int'(bus_if.busy), 0);
      start_rise("arst", 4);
      chk("arst_slot0", int'(bus_if.slot), 0);
      chk("arst_msb", int'(bus_if.bit_idx), 15);

      // prescale 3 -> 0 while running
      bus_if.prescale = 16'd3;
      n  = 0;
      k  = 0;
      pw = bus_if.sck;
      while (k < 2 && n < 100) begin
         tick();
         n++;
         if (bus_if.sck && !pw) k++;
         pw = bus_if.sck;
      end
      bus_if.prescale = 16'd0;
      gap = 0;
      k   = 0;
      nb  = 0;
      nf  = 0;
      n   = 0;
      while (k < 16 && n < 200) begin
         tick();
         n++;
         gap++;
         if (bus_if.bit_strobe) nb++;
         if (bus_if.sck != pw) begin
            if (!bus_if.sck) nf++;
            if (k < 5) iv[k] = gap;
            gap = 0;
            k++;
         end
         pw = bus_if.sck;
      end
      chk("ps_iv0", iv[0], 4);
      chk("ps_iv1", iv[1], 1);
      chk("ps_iv2", iv[2], 1);
      chk("ps_iv3", iv[3], 1);
      chk("ps_iv4", iv[4], 1);
      chk("ps_falls", nf, 8);
      chk("ps_strobes", nb, 8);
      stop_idle("ps");

      // left-justified with zero cfg treated as 1
      bus_if.prescale      = 16'd1;
      bus_if.cfg_mode      = 2'd1;
      bus_if.cfg_slot_bits = 5'd0;
      bus_if.cfg_slots     = 3'd0;
      start_rise("lj", 3);
      chk("lj_ws_start", int'(bus_if.ws), 1);
      run_frame(-1, 5'd0, nb, wu, wd, nc);
      chk("lj_nbs", nb, 4);
      chk("lj_ws_dn", wd, 2);
      chk("lj_ws_up", wu, 4);
      stop_idle("lj");
      chk("lj_idle_ws", int'(bus_if.ws), 1);
      chk("lj_idle_sck", int'(bus_if.sck), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
